// File: rtl/mem_resp_pkg.sv
// Shared types and sizing helpers for the memory read responder.
package mem_resp_pkg;

  // Handshake FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Address width for a given array depth (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of the shared wait/gap down-counter, which holds at most max(a,b)-1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x DATA_W register file: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module mem_resp_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  // Write port: a write lands at the clock edge, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/mem_read_responder.sv
// Memory-side responder for the level-sensitive read handshake.
// While mem_read is high, returns one word per beat with a one-cycle data_ready
// pulse after WAIT_CYCLES wait states, followed by GAP_CYCLES idle cycles.
// Optional feature: define MEM_RESP_PARITY_EN to add the data_par output
// (even parity of data_bus, registered alongside it).
module mem_read_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 3,
  parameter int GAP_CYCLES  = 1,
  parameter int ADDR_W      = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  output logic              data_ready,
  output logic [DATA_W-1:0] data_bus,
  output logic              busy,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
`ifdef MEM_RESP_PARITY_EN
  ,
  output logic              data_par
`endif
);

  localparam int CNT_W = cnt_width(WAIT_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W-1:0] ptr_sel;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] data_bus_reg;
  logic              capture;

  // An addr_load in IDLE applies immediately, so a coincident accept uses the new address.
  assign ptr_sel = (state_reg == IDLE && addr_load) ? addr_in : rd_ptr_reg;

  mem_resp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (ptr_sel),
    .rd_data (rd_word)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; capture marks the edge that enters READY.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_read) begin
          if (WAIT_CYCLES == 0) begin
            state_next = READY;
            capture    = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!mem_read) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = READY;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      READY: begin
        if (GAP_CYCLES > 0) begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      GAP: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Read pointer: load in IDLE, advance (with wrap) as each word is captured.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    if (state_reg == IDLE && addr_load) begin
      rd_ptr_next = addr_in;
    end
    if (capture) begin
      rd_ptr_next = (ptr_sel == LAST_ADDR) ? '0 : ptr_sel + 1'b1;
    end
  end

  // Datapath registers: counter, pointer and the word held on data_bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      rd_ptr_reg   <= '0;
      data_bus_reg <= '0;
    end else begin
      cnt_reg    <= cnt_next;
      rd_ptr_reg <= rd_ptr_next;
      if (capture) begin
        data_bus_reg <= rd_word;
      end
    end
  end

  assign data_ready = (state_reg == READY);
  assign busy       = (state_reg != IDLE);
  assign data_bus   = data_bus_reg;

`ifdef MEM_RESP_PARITY_EN
  logic data_par_reg;

  // Parity is captured on the same edge as the word so both stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_par_reg <= 1'b0;
    end else if (capture) begin
      data_par_reg <= ^rd_word;
    end
  end

  assign data_par = data_par_reg;
`endif

endmodule

// File: tb/tb_mem_read_responder.sv
// Bench for mem_read_responder: two instances (3/1 and 0/0 wait/gap) share one
// stimulus stream; a timeline model predicts every beat, plus directed scenarios.
module tb_mem_read_responder;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read;
  logic          addr_load;
  logic [AW-1:0] addr_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic [1:0]    dr;
  logic [1:0]    bsy;
  logic [DW-1:0] bus_q [2];
`ifdef MEM_RESP_PARITY_EN
  logic [1:0]    par;
`endif

  always #5 clk = ~clk;

  mem_read_responder #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(3), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read),
    .data_ready(dr[0]), .data_bus(bus_q[0]), .busy(bsy[0]),
    .addr_load(addr_load), .addr_in(addr_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef MEM_RESP_PARITY_EN
    , .data_par(par[0])
`endif
  );

  mem_read_responder #(.DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0), .GAP_CYCLES(0)) dut_fast (
    .clk(clk), .rst(rst), .mem_read(mem_read),
    .data_ready(dr[1]), .data_bus(bus_q[1]), .busy(bsy[1]),
    .addr_load(addr_load), .addr_in(addr_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef MEM_RESP_PARITY_EN
    , .data_par(par[1])
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- timeline reference model ----------------
  // A beat accepted at edge a completes at edge a+W if mem_read stays high on
  // edges a+1..a+W; the next request can be sampled at edge a+W+G+2.
  int            wc [2] = '{3, 0};
  int            gc [2] = '{1, 0};
  logic [DW-1:0] mmem [DEPTH];
  longint        edge_cnt = 0;
  int            m_ptr [2];
  int            m_bptr [2];
  bit            m_active [2];
  longint        m_acc [2];
  longint        m_next [2];
  bit            exp_dr [2];
  bit            exp_busy [2];
  logic [DW-1:0] exp_bus [2];

  task automatic take_beat(input int i);
    exp_bus[i]  = mmem[m_bptr[i]];
    m_ptr[i]    = (m_bptr[i] + 1) % DEPTH;
    exp_dr[i]   = 1'b1;
    m_next[i]   = edge_cnt + gc[i] + 2;
    m_active[i] = 1'b0;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_dr[i] = 1'b0;
      if (rst) begin
        m_ptr[i]    = 0;
        m_active[i] = 1'b0;
        m_next[i]   = 0;
        exp_bus[i]  = '0;
      end else if (m_active[i]) begin
        if (!mem_read) begin
          m_active[i] = 1'b0;
          m_next[i]   = edge_cnt + 1;
        end else if (edge_cnt == m_acc[i] + wc[i]) begin
          take_beat(i);
        end
      end else if (edge_cnt >= m_next[i]) begin
        if (addr_load) m_ptr[i] = int'(addr_in);
        if (mem_read) begin
          m_acc[i]  = edge_cnt;
          m_bptr[i] = m_ptr[i];
          if (wc[i] == 0) take_beat(i);
          else m_active[i] = 1'b1;
        end
      end
      exp_busy[i] = m_active[i] || (edge_cnt + 1 < m_next[i]);
    end
    if (wr_en) mmem[wr_addr] = wr_data;
    edge_cnt++;
  end

  // Compare both instances against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (edge_cnt > 0) begin
      for (int i = 0; i < 2; i++) begin
        check_eq($sformatf("data_ready[%0d]", i), 32'(dr[i]), 32'(exp_dr[i]));
        check_eq($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(exp_busy[i]));
        check_eq($sformatf("data_bus[%0d]", i), 32'(bus_q[i]), 32'(exp_bus[i]));
`ifdef MEM_RESP_PARITY_EN
        check_eq($sformatf("data_par[%0d]", i), 32'(par[i]), 32'(^exp_bus[i]));
`endif
        if (exp_dr[i])
          $display("beat inst%0d t=%0t data=%02h", i, $time, exp_bus[i]);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts negedges until inst pulses; -1 if the bound expires.
  task automatic wait_pulse(input int inst, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (dr[inst]) begin
        n = k;
        return;
      end
    end
  endtask

  initial begin
    int n;
    int cnt;
    rst = 1'b1; mem_read = 1'b0; addr_load = 1'b0; addr_in = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step(1);
    // Fill the whole array while in reset.
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i);
      case (i)
        0:       wr_data = 8'hDE;
        1:       wr_data = 8'hAD;
        2:       wr_data = 8'h11;
        15:      wr_data = 8'hF5;
        default: wr_data = DW'($urandom);
      endcase
      step(1);
    end
    wr_en = 1'b0;
    check_eq("reset_ready", 32'(dr[0]), 32'd0);
    check_eq("reset_busy", 32'(bsy[0]), 32'd0);
    check_eq("reset_bus", 32'(bus_q[0]), 32'd0);
    rst = 1'b0;
    step(2);

    // 1: held request, first beat after 4 cycles, then period W+G+2 = 6.
    mem_read = 1'b1;
    wait_pulse(0, 20, n);
    check_eq("t1_latency", n, 4);
    check_eq("t1_word0", 32'(bus_q[0]), 32'hDE);
    wait_pulse(0, 20, n);
    check_eq("t1_period", n, 6);
    check_eq("t1_word1", 32'(bus_q[0]), 32'hAD);
    mem_read = 1'b0;
    step(8);

    // 2: abort in WAIT, then the same word (mem[2]) comes back.
    mem_read = 1'b1;
    cnt = 0;
    for (int k = 0; k < 2; k++) begin step(1); if (dr[0]) cnt++; end
    mem_read = 1'b0;
    for (int k = 0; k < 8; k++) begin step(1); if (dr[0]) cnt++; end
    check_eq("t2_no_pulse", cnt, 0);
    mem_read = 1'b1;
    wait_pulse(0, 20, n);
    check_eq("t2_latency", n, 4);
    check_eq("t2_same_word", 32'(bus_q[0]), 32'h11);
    mem_read = 1'b0;
    step(8);

    // 3: load address 15 with the request, expect wrap to 0.
    addr_load = 1'b1; addr_in = 4'd15; mem_read = 1'b1;
    wait_pulse(0, 20, n);
    addr_load = 1'b0;
    check_eq("t3_latency", n, 4);
    check_eq("t3_word15", 32'(bus_q[0]), 32'hF5);
    wait_pulse(0, 20, n);
    check_eq("t3_wrap_word0", 32'(bus_q[0]), 32'hDE);
    mem_read = 1'b0;
    step(8);

    // 4: write mem[2] on the capture edge -> old data; next pass sees new data.
    addr_load = 1'b1; addr_in = 4'd2; mem_read = 1'b1;
    step(1);
    addr_load = 1'b0;
    step(2);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h55;
    step(1);
    wr_en = 1'b0;
    check_eq("t4_pulse", 32'(dr[0]), 32'd1);
    check_eq("t4_old_data", 32'(bus_q[0]), 32'h11);
    mem_read = 1'b0;
    step(8);
    addr_load = 1'b1; addr_in = 4'd2; mem_read = 1'b1;
    wait_pulse(0, 20, n);
    addr_load = 1'b0;
    check_eq("t4_new_data", 32'(bus_q[0]), 32'h55);
    mem_read = 1'b0;
    step(8);

    // 5: reset during WAIT.
    mem_read = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    check_eq("t5_ready", 32'(dr[0]), 32'd0);
    check_eq("t5_busy", 32'(bsy[0]), 32'd0);
    check_eq("t5_bus", 32'(bus_q[0]), 32'd0);
    rst = 1'b0;
    wait_pulse(0, 20, n);
    check_eq("t5_ptr_zero", 32'(bus_q[0]), 32'hDE);
    mem_read = 1'b0;
    step(8);

    // 6: zero wait/gap instance pulses every second cycle; parity of 8'h07.
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h07;
    step(1);
    wr_en = 1'b0;
    addr_load = 1'b1; addr_in = 4'd5; mem_read = 1'b1;
    step(1);
    addr_load = 1'b0;
    check_eq("t6_pulse", 32'(dr[1]), 32'd1);
    check_eq("t6_word", 32'(bus_q[1]), 32'h07);
`ifdef MEM_RESP_PARITY_EN
    check_eq("t6_parity", 32'(par[1]), 32'd1);
`endif
    cnt = 0;
    for (int k = 0; k < 10; k++) begin step(1); if (dr[1]) cnt++; end
    check_eq("t6_rate", cnt, 5);
    mem_read = 1'b0;
    step(4);

    // Random phase: model checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(5) == 0) mem_read = ~mem_read;
      addr_load = ($urandom_range(7) == 0);
      addr_in   = AW'($urandom);
      wr_en     = ($urandom_range(2) == 0);
      wr_addr   = AW'($urandom);
      wr_data   = DW'($urandom);
      rst       = ($urandom_range(249) == 0);
      step(1);
    end
    rst = 1'b0; mem_read = 1'b0; addr_load = 1'b0; wr_en = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
